// File: rtl/mux_16to1_if.sv
// Bus bundle for the registered 16-to-1 bit selector.
interface mux_16to1_if;
    localparam int unsigned LANES = 16;
    localparam int unsigned SEL_W = 4;

    logic [LANES-1:0] i;
    logic [SEL_W-1:0] s;
    logic             en;
    logic             out;
    logic             out_valid;

    modport master (
        output i,
        output s,
        output en,
        input  out,
        input  out_valid
    );

    modport slave (
        input  i,
        input  s,
        input  en,
        output out,
        output out_valid
    );
endinterface

// File: rtl/mux_16to1.sv
// Registered 16-to-1 single-bit selector with optional combinational bypass.
module mux_16to1 #(
    parameter int unsigned OUT_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    mux_16to1_if.slave  bus
);
    localparam int unsigned LANES  = 16;
    localparam int unsigned L1_W   = LANES / 2;
    localparam int unsigned L2_W   = LANES / 4;
    localparam int unsigned L3_W   = LANES / 8;
    localparam bit          REG_EN = (OUT_REG != 0);

    logic [L1_W-1:0] lvl1;
    logic [L2_W-1:0] lvl2;
    logic [L3_W-1:0] lvl3;
    logic            sel;
    logic            out_q;
    logic            valid_q;

    // Four-level binary tree of 2:1 muxes; a known select never looks at unselected lanes.
    always_comb begin
        lvl1 = '0;
        lvl2 = '0;
        lvl3 = '0;
        sel  = 1'b0;
        for (int k = 0; k < int'(L1_W); k++) begin
            lvl1[k] = bus.s[0] ? bus.i[2*k+1] : bus.i[2*k];
        end
        for (int k = 0; k < int'(L2_W); k++) begin
            lvl2[k] = bus.s[1] ? lvl1[2*k+1] : lvl1[2*k];
        end
        for (int k = 0; k < int'(L3_W); k++) begin
            lvl3[k] = bus.s[2] ? lvl2[2*k+1] : lvl2[2*k];
        end
        sel = bus.s[3] ? lvl3[1] : lvl3[0];
    end

    // Output register: loads on enabled edges, valid sticks until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (bus.en) begin
            out_q   <= sel;
            valid_q <= 1'b1;
        end
    end

    // Registered build drives from the flops; bypass build follows the tree directly.
    assign bus.out       = REG_EN ? out_q   : sel;
    assign bus.out_valid = REG_EN ? valid_q : 1'b1;
endmodule

// File: tb/tb_mux_16to1.sv
// Scoreboard bench for mux_16to1: registered and combinational builds.
module tb_mux_16to1;
    typedef struct {
        logic  exp_out;
        logic  exp_valid;
        string tag;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    mux_16to1_if bus_r ();
    mux_16to1_if bus_c ();

    mux_16to1 #(.OUT_REG(1)) u_reg  (.clk(clk), .rst(rst), .bus(bus_r));
    mux_16to1 #(.OUT_REG(0)) u_comb (.clk(clk), .rst(rst), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b exp %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; the expected post-edge outputs are queued at the edge.
    task automatic step(input logic [15:0] iv, input logic [3:0] sv, input logic ev,
                        input logic eo, input logic evld, input string tag);
        exp_t e;
        bus_r.i  = iv;
        bus_r.s  = sv;
        bus_r.en = ev;
        @(posedge clk);
        e.exp_out   = eo;
        e.exp_valid = evld;
        e.tag       = tag;
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: compare presented outputs against queued expectations away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.tag, "_out"},   bus_r.out,       e.exp_out);
                check({e.tag, "_valid"}, bus_r.out_valid, e.exp_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pat;
        logic [15:0] xv;
        int          wait_cnt;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        bus_r.i  = 16'h0000;
        bus_r.s  = 4'd0;
        bus_r.en = 1'b0;
        bus_c.i  = 16'h0000;
        bus_c.s  = 4'd0;
        bus_c.en = 1'b0;
        #1;
        check("init_rst_out",   bus_r.out,       1'b0);
        check("init_rst_valid", bus_r.out_valid, 1'b0);
        check("comb_valid_rst", bus_c.out_valid, 1'b1);

        // Clocked enabled edges under reset must not load.
        step(16'hFFFF, 4'd7, 1'b1, 1'b0, 1'b0, "in_rst");
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(16'hFFFF, 4'd7, 1'b1, 1'b1, 1'b1, "first_cap");

        // Asynchronous reset mid-cycle discards the held 1.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out",   bus_r.out,       1'b0);
        check("async_rst_valid", bus_r.out_valid, 1'b0);
        step(16'hFFFF, 4'd7, 1'b1, 1'b0, 1'b0, "rst_hold");
        step(16'hFFFF, 4'd7, 1'b1, 1'b0, 1'b0, "rst_hold");
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(16'hFFFF, 4'd7, 1'b1, 1'b1, 1'b1, "rst_release");

        // One-hot walk: selected lane hot, then neighbour lane cold.
        for (int k = 0; k < 16; k++)
            step(16'h0001 << k, 4'(k), 1'b1, 1'b1, 1'b1, "onehot_hit");
        for (int k = 0; k < 16; k++)
            step(16'h0001 << k, 4'((k + 1) % 16), 1'b1, 1'b0, 1'b1, "onehot_miss");

        // Inverse walk: selected lane cold, opposite lane hot.
        for (int k = 0; k < 16; k++)
            step(~(16'h0001 << k), 4'(k), 1'b1, 1'b0, 1'b1, "inv_hit");
        for (int k = 0; k < 16; k++)
            step(~(16'h0001 << k), 4'((k + 8) % 16), 1'b1, 1'b1, 1'b1, "inv_far");

        // Enable hold, then re-enable.
        step(16'h8000, 4'd15, 1'b1, 1'b1, 1'b1, "hold_cap");
        for (int k = 0; k < 3; k++)
            step(16'h0000, 4'd15, 1'b0, 1'b1, 1'b1, "hold");
        step(16'h0000, 4'd15, 1'b1, 1'b0, 1'b1, "hold_release");

        // Enable toggled every cycle: only enabled edges update.
        step(16'h0010, 4'd4, 1'b1, 1'b1, 1'b1, "tog_a");
        step(16'h0000, 4'd4, 1'b0, 1'b1, 1'b1, "tog_b");
        step(16'h0000, 4'd4, 1'b1, 1'b0, 1'b1, "tog_c");
        step(16'h0400, 4'd10, 1'b0, 1'b0, 1'b1, "tog_d");
        step(16'h0400, 4'd10, 1'b1, 1'b1, 1'b1, "tog_e");

        // X on unselected lanes must not reach the output.
        xv = {15'bx, 1'b1};
        step(xv, 4'd0, 1'b1, 1'b1, 1'b1, "x_lanes");
        xv = {1'b0, 15'bx};
        step(xv, 4'd15, 1'b1, 1'b0, 1'b1, "x_lanes_hi");

        // Combinational build: 16'hA5A5 swept without clock dependence.
        pat     = 16'hA5A5;
        bus_c.i = pat;
        bus_c.en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bus_c.s = 4'(k);
            #1;
            check("comb_out",   bus_c.out,       pat[k]);
            check("comb_valid", bus_c.out_valid, 1'b1);
        end
        bus_c.i = {15'bx, 1'b1};
        bus_c.s = 4'd0;
        #1;
        check("comb_x_lanes", bus_c.out, 1'b1);

        // Drain scoreboard with a bounded wait.
        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending exp 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_16to1.md
# mux_16to1

Registered 16-to-1 single-bit selector. It picks one of sixteen input lines, using a 4-bit select, and presents the chosen bit on `out` from a flop. It serves as a leaf selection element in datapath and test-observation logic, where a clean, glitch-free, reset-defined output is required. A parameter allows a purely combinational build.

## Interface
Parameters:
- `OUT_REG`, default 1: 1 = output registered (1-cycle latency); 0 = combinational bypass, and `clk`/`rst` are ignored for `out`.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `i`    input  16  data lines; `i[k]` is lane k.
- `s`    input  4  select; unsigned index 0..15.
- `en`   input  1  capture enable; 1 = update `out` this edge, 0 = hold.
- `out`  output 1  selected bit, `i[s]`.
- `out_valid`  output 1  high once `out` holds a bit captured after the last reset.

## Operation
- Selection is `sel = i[s]`, with s = 4'b0000 selecting `i[0]` through s = 4'b1111 selecting `i[15]`.
- All 16 select codes are legal. There is no default or out-of-range case.
- Sel is pure combinational decode: a 4-level binary tree of 2:1 muxes, or an equivalent case statement.
- No latches are permitted: every code assigns `sel`.
- With `OUT_REG=1`:
  - On each rising `clk` with `en=1`, the output register loads `sel`.
  - With `en=0`, the register holds.
  - `out_valid` sets to 1 on the first enabled capture after reset and stays 1 until the next reset.
- With `OUT_REG=0`:
  - `out = sel` combinationally.
  - `out_valid` is tied to 1.
  - `en` is ignored.
- X/Z on a non-selected lane must not affect `out`.
- X on `s` may propagate as X in simulation. No X-masking is required.

## Timing
- Reset (`OUT_REG=1`):
  - Asserting `rst` drives `out=0` and `out_valid=0` immediately, without waiting for `clk`.
  - Both outputs stay 0 while `rst` is high, regardless of `en`, `i` or `s`.
- Reset release:
  - The first rising edge with `rst=0` and `en=1` loads `sel` and sets `out_valid=1`.
  - Release must be synchronised externally to meet recovery/removal. The block adds no synchroniser.
- Latency: with `OUT_REG=1`, inputs sampled at edge N appear on `out` after edge N and hold until the next enabled edge. Latency is 1 cycle.
- Simultaneous change of `i` and `s` in the same cycle: the value captured is `i[s]` using both new values as settled before the edge.
- Reset mid-operation: `out` goes to 0 asynchronously. The held value is discarded.
- `en` toggled every cycle: `out` changes only on edges where `en=1`.
- Combinational path `i`/`s` -> register D is at most 4 mux levels. This must meet one clock period at target frequency.

## Test plan
- **Reset:** assert `rst` mid-cycle with `i=16'hFFFF`, `s=4'd7`, `en=1`. Required: `out=0` and `out_valid=0` at once, held until release. After release, the next edge gives `out=1`, `out_valid=1`.
- **One-hot walk:** for k=0..15, set `i=16'h0001<<k`, `s=k`, `en=1`, one clock each. Required: `out=1` one cycle after each step. Then repeat with `s=(k+1)%16`. Required: `out=0` every step.
- **Inverse walk:** `i=~(16'h0001<<k)`, `s=k`. Required: `out=0`. With `s=(k+8)%16`, required: `out=1`.
- **Enable hold:** capture `out=1` (`i=16'h8000`, `s=15`), then `en=0`, `i=16'h0000` for 3 cycles. Required: `out` stays 1. Re-assert `en`. Required: `out=0` after the next edge.
- **Non-selected X:** `i=16'bx...x1` (bit0=1, others X), `s=0`. Required: `out=1`, never X.
- **Combinational build:** `OUT_REG=0`, `i=16'hA5A5`, sweep s=0..15 with no clock. Required: `out` follows the pattern 1,0,1,0,0,1,0,1,… (= `i[s]`) within the same delta/time step, and `out_valid=1` throughout.
